// File: rtl/tblink_rpc_invoke_arb.sv
// ---------------------------------------------------------------------------
// tblink_rpc_invoke_arb
//
// Merges method-invocation requests from N_CHANNELS BFM-side channels into a
// single tagged request stream toward the endpoint transport. Blocking calls
// lock their channel (busy) until the matching response returns. Responses
// are routed back to the owning channel as a one-cycle pulse.
//
// Optional feature macro: TBLINK_RPC_INVOKE_ARB_TIMEOUT_EN
//   When defined, a per-channel watchdog releases a blocking call after
//   TIMEOUT_CYCLES cycles and reports it on err_timeout / err_chan.
//
// Ports:
//   clock, reset_n       sole rising-edge clock, async active-low reset
//   req_valid/req_ready  per-channel request handshake (ready one-hot or 0)
//   req_blocking         per-channel blocking flag
//   req_method/params    per-channel payload, channel i at slice i
//   out_valid/out_ready  transport-side request handshake (FIFO head)
//   out_chan/blocking/method/params  FIFO head payload (0 when empty)
//   rsp_valid/chan/data  transport response, always accepted
//   chan_rsp_valid       one-cycle pulse to the target channel
//   chan_rsp_data        registered return value, shared bus
//   busy                 channel has a blocking call outstanding
//   err_unexp            pulse: response to a non-busy / out-of-range channel
//   err_timeout,err_chan (macro only) watchdog pulse and offending channel
// ---------------------------------------------------------------------------
module tblink_rpc_invoke_arb #(
  parameter int N_CHANNELS     = 4,
  parameter int METHOD_W       = 8,
  parameter int PARAM_W        = 64,
  parameter int DEPTH          = 4,
`ifdef TBLINK_RPC_INVOKE_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 1024,
`endif
  localparam int CHAN_W        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [N_CHANNELS-1:0]          req_valid,
  output logic [N_CHANNELS-1:0]          req_ready,
  input  logic [N_CHANNELS-1:0]          req_blocking,
  input  logic [N_CHANNELS*METHOD_W-1:0] req_method,
  input  logic [N_CHANNELS*PARAM_W-1:0]  req_params,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHAN_W-1:0]              out_chan,
  output logic                           out_blocking,
  output logic [METHOD_W-1:0]            out_method,
  output logic [PARAM_W-1:0]             out_params,
  input  logic                           rsp_valid,
  input  logic [CHAN_W-1:0]              rsp_chan,
  input  logic [PARAM_W-1:0]             rsp_data,
  output logic [N_CHANNELS-1:0]          chan_rsp_valid,
  output logic [PARAM_W-1:0]             chan_rsp_data,
  output logic [N_CHANNELS-1:0]          busy,
`ifdef TBLINK_RPC_INVOKE_ARB_TIMEOUT_EN
  output logic                           err_timeout,
  output logic [CHAN_W-1:0]              err_chan,
`endif
  output logic                           err_unexp
);

  localparam int PTR_W = $clog2(DEPTH);

  // Request FIFO storage and control
  logic [CHAN_W-1:0]   mem_chan   [DEPTH];
  logic                mem_blk    [DEPTH];
  logic [METHOD_W-1:0] mem_method [DEPTH];
  logic [PARAM_W-1:0]  mem_params [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  // Arbitration
  logic [CHAN_W-1:0]     rr_ptr;
  logic [N_CHANNELS-1:0] eligible;
  logic                  grant_found;
  logic [CHAN_W-1:0]     grant_idx;
  logic [N_CHANNELS-1:0] grant_onehot;
  int                    search_idx;
  logic                  push_blk;
  logic [METHOD_W-1:0]   push_method;
  logic [PARAM_W-1:0]    push_params;

  // Response / lock tracking
  logic [N_CHANNELS-1:0] rsp_hit_vec;
  logic                  rsp_hit;
  logic [N_CHANNELS-1:0] timeout_vec;
  logic [N_CHANNELS-1:0] busy_nxt;

  assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign push       = grant_found && !fifo_full;
  assign req_ready  = grant_onehot;

  // The head payload is forced to zero while the FIFO is empty so stale
  // entries never appear on the transport bus.
  assign out_chan     = out_valid ? mem_chan[rd_ptr]   : '0;
  assign out_blocking = out_valid ? mem_blk[rd_ptr]    : 1'b0;
  assign out_method   = out_valid ? mem_method[rd_ptr] : '0;
  assign out_params   = out_valid ? mem_params[rd_ptr] : '0;

  // Round-robin search starting at rr_ptr and wrapping. Busy channels are
  // never eligible, and the grant is suppressed when the FIFO is full before
  // any pop this cycle (no bypass of a full FIFO).
  always_comb begin
    eligible     = req_valid & ~busy;
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    search_idx   = 0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      search_idx = int'(rr_ptr) + k;
      if (search_idx >= N_CHANNELS) begin
        search_idx = search_idx - N_CHANNELS;
      end
      if (!grant_found && eligible[CHAN_W'(search_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = CHAN_W'(search_idx);
      end
    end
    if (grant_found && !fifo_full) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

  assign push_blk    = req_blocking[grant_idx];
  assign push_method = req_method[grant_idx*METHOD_W +: METHOD_W];
  assign push_params = req_params[grant_idx*PARAM_W +: PARAM_W];

  // Decode which busy channel (if any) the incoming response releases.
  // An out-of-range rsp_chan matches nothing and therefore reports err_unexp.
  always_comb begin
    rsp_hit_vec = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      rsp_hit_vec[i] = rsp_valid && (rsp_chan == CHAN_W'(i)) && busy[i];
    end
  end

  assign rsp_hit = |rsp_hit_vec;

`ifdef TBLINK_RPC_INVOKE_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]   to_cnt [N_CHANNELS];
  logic [CHAN_W-1:0] to_chan;

  // A channel times out after TIMEOUT_CYCLES busy cycles; a response in the
  // same cycle wins and suppresses the timeout.
  always_comb begin
    timeout_vec = '0;
    to_chan     = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (busy[i] && !rsp_hit_vec[i] &&
          (to_cnt[i] == TO_W'(TIMEOUT_CYCLES - 1))) begin
        timeout_vec[i] = 1'b1;
        to_chan        = CHAN_W'(i);
      end
    end
  end

  // Watchdog counters run only while their channel is locked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        to_cnt[i] <= '0;
      end
      err_timeout <= 1'b0;
      err_chan    <= '0;
    end else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (!busy[i] || rsp_hit_vec[i] || timeout_vec[i]) begin
          to_cnt[i] <= '0;
        end else begin
          to_cnt[i] <= to_cnt[i] + TO_W'(1);
        end
      end
      err_timeout <= |timeout_vec;
      if (|timeout_vec) begin
        err_chan <= to_chan;
      end
    end
  end
`else
  assign timeout_vec = '0;
`endif

  // Next lock state: a blocking accept sets the bit, a matching response or
  // a timeout clears it. Set and clear never target the same channel since
  // grants need !busy and responses need busy.
  always_comb begin
    busy_nxt = busy;
    if (push && push_blk) begin
      busy_nxt[grant_idx] = 1'b1;
    end
    busy_nxt = busy_nxt & ~rsp_hit_vec & ~timeout_vec;
  end

  // FIFO payload storage; no reset needed because the head is masked
  // whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_chan[wr_ptr]   <= grant_idx;
      mem_blk[wr_ptr]    <= push_blk;
      mem_method[wr_ptr] <= push_method;
      mem_params[wr_ptr] <= push_params;
    end
  end

  // FIFO pointers, round-robin pointer, locks and response outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rr_ptr         <= '0;
      busy           <= '0;
      chan_rsp_valid <= '0;
      chan_rsp_data  <= '0;
      err_unexp      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= (grant_idx == CHAN_W'(N_CHANNELS - 1)) ?
                  '0 : grant_idx + CHAN_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
      busy           <= busy_nxt;
      chan_rsp_valid <= rsp_hit_vec;
      if (rsp_hit) begin
        chan_rsp_data <= rsp_data;
      end
      err_unexp <= rsp_valid && !rsp_hit;
    end
  end

endmodule
